// File: rtl/sram_line_adapter_pkg.sv
// Shared definitions for the line-to-word SRAM adapter: default geometry and FSM state encodings.
package sram_line_adapter_pkg;

    localparam int DEF_LINE_WIDTH   = 128;
    localparam int DEF_WORD_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 20;
    localparam int DEF_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/sram_rd_beat_pipe.sv
// Shift register of {valid, beat index} that tracks each read beat through the SRAM read latency,
// so the returning sram_dout0 word can be steered into its line slot.
module sram_rd_beat_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_push_valid,
    input  logic [IDX_W-1:0] i_push_idx,
    output logic             o_pop_valid,
    output logic [IDX_W-1:0] o_pop_idx
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][IDX_W-1:0] r_idx;

    // Advance the beat tags one stage per clock; a flush drops every tag in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= {DEPTH{1'b0}};
            r_idx   <= {(DEPTH * IDX_W){1'b0}};
        end else if (i_flush) begin
            r_valid <= {DEPTH{1'b0}};
        end else begin
            r_valid[0] <= i_push_valid;
            r_idx[0]   <= i_push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_pop_valid = r_valid[DEPTH-1];
    assign o_pop_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/sram_line_adapter.sv
// Line-to-word adapter between a cache-line memory port and a single-port OpenRAM macro.
// Define SRAM_WMASK_EN to add per-byte write masks (req_wmask / sram_wmask0).
module sram_line_adapter
    import sram_line_adapter_pkg::*;
#(
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    input  logic                  abort,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_WIDTH-1:0] resp_rdata,
    output logic                  busy,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [WORD_WIDTH-1:0] load_data,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [WORD_WIDTH-1:0] sram_din0,
    input  logic [WORD_WIDTH-1:0] sram_dout0
`ifdef SRAM_WMASK_EN
    ,
    input  logic [LINE_WIDTH/8-1:0] req_wmask,
    output logic [WORD_WIDTH/8-1:0] sram_wmask0
`endif
);

    localparam int BEATS = LINE_WIDTH / WORD_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
`ifdef SRAM_WMASK_EN
    localparam int MASK_W  = WORD_WIDTH / 8;
    localparam int LMASK_W = LINE_WIDTH / 8;
`endif

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_resp_valid;
    logic [LINE_WIDTH-1:0] r_resp_rdata;
    logic                  r_csb;
    logic                  r_web;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_din;
`ifdef SRAM_WMASK_EN
    logic [LMASK_W-1:0]    r_wmask_line;
    logic [MASK_W-1:0]     r_wmask;
`endif

    logic             w_kill;
    logic             w_accept;
    logic             w_push;
    logic             w_pop_valid;
    logic [CNT_W-1:0] w_pop_idx;
    logic             w_sample;
    logic             w_last;

    // A preload while busy cancels the transaction exactly like abort.
    assign w_kill   = (r_state != ST_IDLE) && (abort || load_en);
    assign w_accept = req_valid && req_ready;
    assign w_push   = (r_state == ST_READ) && !w_kill;
    assign w_sample = w_pop_valid && !w_kill;
    assign w_last   = (r_cnt == CNT_LAST);

    sram_rd_beat_pipe #(
        .DEPTH (READ_LATENCY),
        .IDX_W (CNT_W)
    ) u_rd_beat_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_flush      (w_kill),
        .i_push_valid (w_push),
        .i_push_idx   (r_cnt),
        .o_pop_valid  (w_pop_valid),
        .o_pop_idx    (w_pop_idx)
    );

    // Transaction FSM; SRAM pins are registered and default to the idle pattern each cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_wdata      <= {LINE_WIDTH{1'b0}};
            r_resp_valid <= 1'b0;
            r_resp_rdata <= {LINE_WIDTH{1'b0}};
            r_csb        <= 1'b1;
            r_web        <= 1'b1;
            r_addr       <= {ADDR_WIDTH{1'b0}};
            r_din        <= {WORD_WIDTH{1'b0}};
`ifdef SRAM_WMASK_EN
            r_wmask_line <= {LMASK_W{1'b1}};
            r_wmask      <= {MASK_W{1'b1}};
`endif
        end else begin
            r_csb <= 1'b1;
            r_web <= 1'b1;
            r_din <= {WORD_WIDTH{1'b0}};
`ifdef SRAM_WMASK_EN
            r_wmask <= {MASK_W{1'b1}};
`endif
            if (w_sample) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (w_pop_idx == CNT_W'(b)) begin
                        r_resp_rdata[b*WORD_WIDTH +: WORD_WIDTH] <= sram_dout0;
                    end
                end
            end

            if (w_kill) begin
                r_state      <= ST_IDLE;
                r_cnt        <= {CNT_W{1'b0}};
                r_resp_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_cnt  <= {CNT_W{1'b0}};
                            r_csb  <= 1'b0;
                            r_addr <= req_addr;
                            if (req_we) begin
                                r_state <= ST_WRITE;
                                r_web   <= 1'b0;
                                r_din   <= req_wdata[WORD_WIDTH-1:0];
                                r_wdata <= req_wdata >> WORD_WIDTH;
`ifdef SRAM_WMASK_EN
                                r_wmask      <= req_wmask[MASK_W-1:0];
                                r_wmask_line <= req_wmask >> MASK_W;
`endif
                            end else begin
                                r_state <= ST_READ;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (w_last) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + CNT_ONE;
                            r_addr  <= r_addr + ADDR_ONE;
                            r_csb   <= 1'b0;
                            r_web   <= 1'b0;
                            r_din   <= r_wdata[WORD_WIDTH-1:0];
                            r_wdata <= r_wdata >> WORD_WIDTH;
`ifdef SRAM_WMASK_EN
                            r_wmask      <= r_wmask_line[MASK_W-1:0];
                            r_wmask_line <= r_wmask_line >> MASK_W;
`endif
                        end
                    end
                    ST_READ: begin
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt  <= r_cnt + CNT_ONE;
                            r_addr <= r_addr + ADDR_ONE;
                            r_csb  <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        // The last slot arrives READ_LATENCY edges after its address.
                        if (w_sample && (w_pop_idx == CNT_LAST)) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end
                    end
                    ST_RESP: begin
                        if (resp_ready) begin
                            r_state      <= ST_IDLE;
                            r_resp_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_cnt        <= {CNT_W{1'b0}};
                        r_resp_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE) && !load_en;
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

    // The preload bypass owns the SRAM port in the same cycle it is requested.
    assign sram_csb0  = load_en ? 1'b0      : r_csb;
    assign sram_web0  = load_en ? 1'b0      : r_web;
    assign sram_addr0 = load_en ? load_addr : r_addr;
    assign sram_din0  = load_en ? load_data : r_din;
`ifdef SRAM_WMASK_EN
    assign sram_wmask0 = load_en ? {MASK_W{1'b1}} : r_wmask;
`endif

endmodule

// File: tb/tb_sram_line_adapter.sv
// Directed self-checking bench for sram_line_adapter with READ_LATENCY=2 and a behavioural SRAM.
// Byte-mask scenarios run when SRAM_WMASK_EN is defined.
module tb_sram_line_adapter;

    localparam int LW = 128;
    localparam int WW = 32;
    localparam int AW = 20;
    localparam int RL = 2;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = {AW{1'b0}};
    logic [LW-1:0] req_wdata = {LW{1'b0}};
    logic          abort = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [LW-1:0] resp_rdata;
    logic          busy;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = {AW{1'b0}};
    logic [WW-1:0] load_data = {WW{1'b0}};
    logic          sram_csb0;
    logic          sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [WW-1:0] sram_din0;
    logic [WW-1:0] sram_dout0;
`ifdef SRAM_WMASK_EN
    logic [LW/8-1:0] req_wmask = {(LW/8){1'b1}};
    logic [WW/8-1:0] sram_wmask0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    localparam logic [LW-1:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [LW-1:0] L2 = 128'h88888888_77777777_66666666_55555555;

    sram_line_adapter #(
        .LINE_WIDTH   (LW),
        .WORD_WIDTH   (WW),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .abort      (abort),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
`ifdef SRAM_WMASK_EN
        ,
        .req_wmask   (req_wmask),
        .sram_wmask0 (sram_wmask0)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: writes on the edge, read data RL edges after the address edge.
    bit   [WW-1:0] mem [0:(1<<AW)-1];
    logic [WW-1:0] rd_pipe [RL];

    function automatic logic [WW-1:0] merge_word(input logic [WW-1:0] old_w, input logic [WW-1:0] new_w);
        logic [WW-1:0] res;
        res = new_w;
`ifdef SRAM_WMASK_EN
        for (int b = 0; b < WW/8; b++) begin
            res[b*8 +: 8] = sram_wmask0[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
`else
        if (old_w == new_w) res = old_w;
`endif
        return res;
    endfunction

    always @(posedge clk) begin
        if (!sram_csb0) n_acc <= n_acc + 1;
        if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= merge_word(mem[sram_addr0], sram_din0);
        rd_pipe[0] <= (!sram_csb0 && sram_web0) ? mem[sram_addr0] : {WW{1'b0}};
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_dout0 = rd_pipe[RL-1];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_release", 128'({resp_valid, busy}), 128'(2'b00));
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] line);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = line;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wr_pins", 128'({resp_valid, sram_csb0, sram_web0, sram_addr0, sram_din0}),
                  128'({1'b0, 1'b0, 1'b0, a + AW'(k), line[k*WW +: WW]}));
            tick();
        end
        check("wr_resp_cycle5", 128'({resp_valid, busy, sram_csb0}), 128'(3'b111));
        release_resp();
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [3:0][AW-1:0] ea,
                            input logic [LW-1:0] eline, input logic ab);
        int cyc;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; abort = ab;
        tick();
        req_valid = 1'b0; abort = 1'b0;
        cyc = 1;
        for (int k = 0; k < 4; k++) begin
            check("rd_pins", 128'({resp_valid, sram_csb0, sram_web0, sram_addr0}),
                  128'({1'b0, 1'b0, 1'b1, ea[k]}));
            tick();
            cyc++;
        end
        while (!resp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("rd_latency", 128'(cyc), 128'(4 + RL + 1));
        check("rd_line", resp_rdata, eline);
    endtask

    initial begin
        int acc0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_pins", 128'({sram_csb0, sram_web0, sram_addr0, sram_din0}), 128'({1'b1, 1'b1, 20'h0, 32'h0}));
        check("rst_resp", 128'({resp_valid, busy, req_ready}), 128'(3'b001));
        check("rst_rdata", resp_rdata, 128'h0);
        #10 reset_n = 1'b1;
        tick();
        check("post_rst_ready", 128'({req_ready, busy}), 128'(2'b10));

        // 1: write a line then read it back
        run_write(20'h00100, L1);
        run_read(20'h00100, {20'h00103, 20'h00102, 20'h00101, 20'h00100}, L1, 1'b0);
        release_resp();

        // 2: preload around the address wrap, then read across it
        for (int k = 0; k < 4; k++) begin
            load_en = 1'b1;
            load_addr = 20'hFFFFE + AW'(k);
            load_data = 32'hA0A0A0A0 + WW'(k) * 32'h11111111;
            #1;
            check("load_pins", 128'({req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0}),
                  128'({1'b0, 1'b0, 1'b0, load_addr, load_data}));
            tick();
        end
        load_en = 1'b0;
        run_read(20'hFFFFE, {20'h00001, 20'h00000, 20'hFFFFF, 20'hFFFFE},
                 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 1'b0);

        // 3: response back-pressure
        acc0 = n_acc;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("hold_ctrl", 128'({resp_valid, req_ready, sram_csb0}), 128'(3'b101));
            check("hold_rdata", resp_rdata, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        end
        check("hold_no_access", 128'(n_acc - acc0), 128'(0));
        release_resp();

        // 4: abort in cycle 2 of a read; next request (with abort high in IDLE) is accepted
        req_valid = 1'b1; req_we = 1'b0; req_addr = 20'hFFFFE;
        tick();
        req_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 128'({busy, resp_valid, req_ready}), 128'(3'b001));
        run_read(20'h00100, {20'h00103, 20'h00102, 20'h00101, 20'h00100}, L1, 1'b1);
        release_resp();

        // 5: preload in the middle of a write drops the rest of the line
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00200; req_wdata = L2;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        tick();
        load_en = 1'b1; load_addr = 20'h00010; load_data = 32'hDEADBEEF;
        #1;
        check("mid_load_pins", 128'({req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0}),
              128'({1'b0, 1'b0, 1'b0, 20'h00010, 32'hDEADBEEF}));
`ifdef SRAM_WMASK_EN
        check("mid_load_wmask", 128'(sram_wmask0), 128'(4'hF));
`endif
        tick();
        check("mid_load_drop", 128'({busy, resp_valid, req_ready}), 128'(3'b000));
        load_en = 1'b0;
        #1;
        check("load_release_ready", 128'(req_ready), 128'(1'b1));
        run_read(20'h00200, {20'h00203, 20'h00202, 20'h00201, 20'h00200}, 128'h0_0_0_55555555, 1'b0);
        release_resp();
        run_read(20'h00010, {20'h00013, 20'h00012, 20'h00011, 20'h00010}, 128'h0_0_0_DEADBEEF, 1'b0);
        release_resp();

`ifdef SRAM_WMASK_EN
        // 6: masked write enables only beat 0
        check("idle_wmask", 128'(sram_wmask0), 128'(4'hF));
        req_wmask = 16'h000F;
        run_write(20'h00100, L2);
        req_wmask = 16'hFFFF;
        run_read(20'h00100, {20'h00103, 20'h00102, 20'h00101, 20'h00100},
                 128'h44444444_33333333_22222222_55555555, 1'b0);
        release_resp();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
